// File: rtl/idex_elastic_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : idex_elastic_reg_if
// Description : Decode-to-execute bundle interface for the ID/EX elastic
//               register. Carries the decode-side valid/ready handshake, the
//               micro-command, data and register-number fields, the
//               execute-side handshake with the registered copies, the flush
//               request and the bubble counter.
//               master : driven by the pipeline around the stage
//               slave  : the elastic register itself
// Ports       : (interface signals)
//               flush                      discard all buffered entries
//               in_valid / in_ready        decode-side handshake
//               WB, M, EX                  micro-commands from decode
//               Data1, Data2, imm, PCplus  data words from decode
//               Rs, Rt, Rd                 register numbers from decode
//               out_valid / out_ready      execute-side handshake
//               *_out                      registered bundle toward execute
//               bubble_cnt                 saturating bubble-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
interface idex_elastic_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned WB_W   = 3,
   parameter int unsigned M_W    = 3,
   parameter int unsigned EX_W   = 8,
   parameter int unsigned BCNT_W = 16
);

   // control
   logic              flush;

   // decode side
   logic              in_valid;
   logic              in_ready;
   logic [WB_W-1:0]   WB;
   logic [M_W-1:0]    M;
   logic [EX_W-1:0]   EX;
   logic [DATA_W-1:0] Data1;
   logic [DATA_W-1:0] Data2;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] PCplus;
   logic [REG_W-1:0]  Rs;
   logic [REG_W-1:0]  Rt;
   logic [REG_W-1:0]  Rd;

   // execute side
   logic              out_valid;
   logic              out_ready;
   logic [WB_W-1:0]   WB_out;
   logic [M_W-1:0]    M_out;
   logic [EX_W-1:0]   EX_out;
   logic [DATA_W-1:0] Data1_out;
   logic [DATA_W-1:0] Data2_out;
   logic [DATA_W-1:0] imm_out;
   logic [DATA_W-1:0] PCplus_out;
   logic [REG_W-1:0]  Rs_out;
   logic [REG_W-1:0]  Rt_out;
   logic [REG_W-1:0]  Rd_out;

   // statistics
   logic [BCNT_W-1:0] bubble_cnt;

   modport master (
      output flush,
      output in_valid,
      input  in_ready,
      output WB, M, EX,
      output Data1, Data2, imm, PCplus,
      output Rs, Rt, Rd,
      input  out_valid,
      output out_ready,
      input  WB_out, M_out, EX_out,
      input  Data1_out, Data2_out, imm_out, PCplus_out,
      input  Rs_out, Rt_out, Rd_out,
      input  bubble_cnt
   );

   modport slave (
      input  flush,
      input  in_valid,
      output in_ready,
      input  WB, M, EX,
      input  Data1, Data2, imm, PCplus,
      input  Rs, Rt, Rd,
      output out_valid,
      input  out_ready,
      output WB_out, M_out, EX_out,
      output Data1_out, Data2_out, imm_out, PCplus_out,
      output Rs_out, Rt_out, Rd_out,
      output bubble_cnt
   );

endinterface : idex_elastic_reg_if
`default_nettype wire

// File: rtl/idex_elastic_reg.sv
`default_nettype none
// ============================================================================
// Module      : idex_elastic_reg
// Description : ID/EX pipeline register with valid/ready handshakes on both
//               sides and a two-entry skid buffer (main + skid). The main
//               entry drives the execute-side outputs; the skid entry absorbs
//               one bundle while execute stalls so that in_ready is a pure
//               function of registered state. Supports flush, NOP gating of
//               the WB/M micro-commands whenever no bundle is valid, and a
//               saturating bubble counter.
// Ports       : clk    - clock, all state changes on the rising edge
//               rst_n  - synchronous active-low reset
//               bus    - idex_elastic_reg_if.slave (handshakes, bundle,
//                        flush, bubble_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module idex_elastic_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned WB_W   = 3,
   parameter int unsigned M_W    = 3,
   parameter int unsigned EX_W   = 8,
   parameter int unsigned BCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   idex_elastic_reg_if.slave bus
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int unsigned c_BUNDLE_W = WB_W + M_W + EX_W + 4 * DATA_W + 3 * REG_W;

   // Entry-count states: the state encodes both valid bits
   //   EMPTY : main_valid=0 skid_valid=0
   //   ONE   : main_valid=1 skid_valid=0
   //   TWO   : main_valid=1 skid_valid=1
   localparam logic [1:0] c_ST_EMPTY = 2'd0;
   localparam logic [1:0] c_ST_ONE   = 2'd1;
   localparam logic [1:0] c_ST_TWO   = 2'd2;

   localparam logic [BCNT_W-1:0] c_CNT_ONE = {{(BCNT_W-1){1'b0}}, 1'b1};
   localparam logic [BCNT_W-1:0] c_CNT_MAX = {BCNT_W{1'b1}};

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [1:0]            r_state;
   logic [1:0]            w_state_next;

   logic [c_BUNDLE_W-1:0] r_main_data;
   logic [c_BUNDLE_W-1:0] r_skid_data;
   logic [c_BUNDLE_W-1:0] w_in_bundle;

   logic                  w_main_valid;
   logic                  w_skid_valid;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_keep;

   logic                  w_load_main_in;
   logic                  w_load_main_skid;
   logic                  w_load_skid;

   logic [WB_W-1:0]       w_main_wb;
   logic [M_W-1:0]        w_main_m;

   logic [BCNT_W-1:0]     r_bubble_cnt;

   // -------------------------------------------------------------------------
   // Handshake terms
   // -------------------------------------------------------------------------
   // in_ready depends only on registered state and rst_n, never on out_ready,
   // so no combinational path exists from execute back to decode.
   assign w_in_ready = rst_n & ~w_skid_valid;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_pop      = w_main_valid & bus.out_ready;

   // A flush discards anything arriving this cycle and empties the buffer;
   // datapath loads are suppressed so the outputs stay quiet.
   assign w_keep     = ~bus.flush;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      if (bus.flush) begin
         w_state_next = c_ST_EMPTY;
      end else begin
         case (r_state)
            c_ST_EMPTY: begin
               if (w_accept) begin
                  w_state_next = c_ST_ONE;
               end
            end
            c_ST_ONE: begin
               if (w_accept && !w_pop) begin
                  w_state_next = c_ST_TWO;
               end else if (!w_accept && w_pop) begin
                  w_state_next = c_ST_EMPTY;
               end
            end
            c_ST_TWO: begin
               // in_ready is low here, so only a pop can change the state
               if (w_pop) begin
                  w_state_next = c_ST_ONE;
               end
            end
            default: begin
               w_state_next = c_ST_EMPTY;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FSM: output decode (valid bits of the two entries)
   // -------------------------------------------------------------------------
   always_comb begin
      w_main_valid = 1'b0;
      w_skid_valid = 1'b0;
      case (r_state)
         c_ST_ONE: begin
            w_main_valid = 1'b1;
         end
         c_ST_TWO: begin
            w_main_valid = 1'b1;
            w_skid_valid = 1'b1;
         end
         default: begin
            w_main_valid = 1'b0;
            w_skid_valid = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath load enables
   // -------------------------------------------------------------------------
   // Main takes the incoming bundle when it is empty, or when its current
   // bundle leaves in the same cycle. When main stays occupied, the incoming
   // bundle parks in skid. When execute consumes main while skid holds a
   // bundle, skid advances into main, preserving FIFO order.
   assign w_load_main_in   = w_keep & w_accept & (~w_main_valid | w_pop);
   assign w_load_skid      = w_keep & w_accept & w_main_valid & ~w_pop;
   assign w_load_main_skid = w_keep & w_skid_valid & w_pop;

   assign w_in_bundle = {bus.WB, bus.M, bus.EX,
                         bus.Data1, bus.Data2, bus.imm, bus.PCplus,
                         bus.Rs, bus.Rt, bus.Rd};

   // -------------------------------------------------------------------------
   // Entry storage
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main_data <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
         end else if (w_load_main_in) begin
            r_main_data <= w_in_bundle;
         end

         if (w_load_skid) begin
            r_skid_data <= w_in_bundle;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Bubble counter: counts edges at which no valid bundle is presented to
   // execute; saturates instead of wrapping and survives flush.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bubble_cnt <= '0;
      end else if (!w_main_valid && (r_bubble_cnt != c_CNT_MAX)) begin
         r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign {w_main_wb, w_main_m, bus.EX_out,
           bus.Data1_out, bus.Data2_out, bus.imm_out, bus.PCplus_out,
           bus.Rs_out, bus.Rt_out, bus.Rd_out} = r_main_data;

   // With no valid bundle, WB and M are forced to zero so that execute sees a
   // NOP (no register write, no memory access) whatever main still holds.
   assign bus.WB_out     = w_main_valid ? w_main_wb : '0;
   assign bus.M_out      = w_main_valid ? w_main_m  : '0;

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_main_valid;
   assign bus.bubble_cnt = r_bubble_cnt;

endmodule : idex_elastic_reg
`default_nettype wire
